// File: rtl/ioctl_upload_spi_if.sv
// Signal bundle between the upload SPI transmitter, the host SPI pins and the
// core memory read port.
interface ioctl_upload_spi_if #(
  parameter int unsigned ADDR_W = 25
);
  logic              SPI_SCK;
  logic              SPI_SS;
  logic              SPI_DI;
  logic              spi_do;
  logic              spi_do_oe;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic              ioctl_rd;
  logic [7:0]        ioctl_din;
  logic              ioctl_din_valid;
  logic              underrun;

  modport slave (
    input  SPI_SCK, SPI_SS, SPI_DI, ioctl_din, ioctl_din_valid,
    output spi_do, spi_do_oe, ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
           underrun
  );

  modport master (
    output SPI_SCK, SPI_SS, SPI_DI, ioctl_din, ioctl_din_valid,
    input  spi_do, spi_do_oe, ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
           underrun
  );
endinterface

// File: rtl/ioctl_upload_spi.sv
// SPI-slave upload transmitter: decodes host commands, fetches bytes over the
// ioctl read handshake and shifts them out MSB-first on spi_do.
module ioctl_upload_spi #(
  parameter int unsigned ADDR_W    = 25,
  parameter logic [7:0]  CMD_INDEX = 8'h54,
  parameter logic [7:0]  CMD_START = 8'h55,
  parameter logic [7:0]  CMD_END   = 8'h56,
  parameter logic [7:0]  CMD_READ  = 8'h57
) (
  input logic               clk_sys,
  input logic               res_n,
  ioctl_upload_spi_if.slave bus
);

  // state    | meaning
  // F_CMD    | expecting a command byte (forced while SS high)
  // F_INDEX  | next byte is the upload index
  // F_READ   | every fall transmits; received bytes discarded
  // F_IGNORE | rest of frame ignored
  // X_IDLE   | no fetch outstanding
  // X_WAIT   | fetch issued, waiting for ioctl_din_valid
  typedef enum logic [1:0] {F_CMD, F_INDEX, F_READ, F_IGNORE} frame_t;
  typedef enum logic       {X_IDLE, X_WAIT} fetch_t;

  logic [1:0]        sck_sync_q, ss_sync_q, di_sync_q;
  logic              sck_prev_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_sr_q, rx_sr_d;
  frame_t            frame_q, frame_d;
  fetch_t            fetch_q, fetch_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q;
  logic              upload_q, upload_d;
  logic [7:0]        index_q, index_d;
  logic              underrun_q, underrun_d;
  logic              fetch_req;

  logic       sck_s, ss_s, di_s;
  logic       sck_rise, sck_fall;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       din_ok;
  logic       tx_fall;

  assign sck_s     = sck_sync_q[1];
  assign ss_s      = ss_sync_q[1];
  assign di_s      = di_sync_q[1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign rx_byte   = {rx_sr_q, di_s};
  assign byte_done = sck_rise && !ss_s && (bit_cnt_q == 3'd7);
  // a strobe outside WAIT belongs to no request of ours and is dropped
  assign din_ok    = bus.ioctl_din_valid && (fetch_q == X_WAIT);
  // SS rising together with the last fall ends the frame without a reload
  assign tx_fall   = (frame_q == F_READ) && sck_fall && !ss_s;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      sck_sync_q <= 2'b00;
      ss_sync_q  <= 2'b11;
      di_sync_q  <= 2'b00;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], bus.SPI_SCK};
      ss_sync_q  <= {ss_sync_q[0], bus.SPI_SS};
      di_sync_q  <= {di_sync_q[0], bus.SPI_DI};
      sck_prev_q <= sck_s;
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      frame_q    <= F_CMD;
      fetch_q    <= X_IDLE;
      tx_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      upload_q   <= 1'b0;
      index_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      frame_q    <= frame_d;
      fetch_q    <= fetch_d;
      tx_q       <= tx_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      addr_q     <= addr_d;
      rd_q       <= fetch_req;
      upload_q   <= upload_d;
      index_q    <= index_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    frame_d    = frame_q;
    fetch_d    = fetch_q;
    tx_d       = tx_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    addr_d     = addr_q;
    upload_d   = upload_q;
    index_d    = index_q;
    underrun_d = underrun_q;
    fetch_req  = 1'b0;

    if (ss_s) begin
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_sr_d   = rx_byte[6:0];
    end

    if (din_ok) begin
      buf_d      = bus.ioctl_din;
      buf_full_d = 1'b1;
      fetch_d    = X_IDLE;
    end

    // START after the fill path so a stale return is discarded by the restart
    if (ss_s) begin
      frame_d = F_CMD;
    end else if (byte_done) begin
      case (frame_q)
        F_CMD: begin
          if (rx_byte == CMD_INDEX) begin
            frame_d = F_INDEX;
          end else if (rx_byte == CMD_READ) begin
            frame_d = F_READ;
          end else if (rx_byte == CMD_START) begin
            upload_d   = 1'b1;
            addr_d     = '0;
            underrun_d = 1'b0;
            buf_full_d = 1'b0;
            fetch_req  = 1'b1;
          end else if (rx_byte == CMD_END) begin
            upload_d = 1'b0;
          end else begin
            frame_d = F_IGNORE;
          end
        end
        F_INDEX: begin
          index_d = rx_byte;
          frame_d = F_IGNORE;
        end
        default: ;
      endcase
    end

    if (tx_fall) begin
      if (bit_cnt_q == 3'd0) begin
        if (buf_full_q || din_ok) begin
          tx_d       = buf_full_q ? buf_q : bus.ioctl_din;
          buf_full_d = 1'b0;
          addr_d     = addr_q + ADDR_W'(1);
          fetch_req  = 1'b1;
        end else begin
          tx_d       = 8'hFF;
          underrun_d = 1'b1;
        end
      end else begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end

    if (fetch_req) fetch_d = X_WAIT;
  end

  assign bus.spi_do       = tx_q[7];
  assign bus.spi_do_oe    = (frame_q == F_READ) && !bus.SPI_SS;
  assign bus.ioctl_upload = upload_q;
  assign bus.ioctl_index  = index_q;
  assign bus.ioctl_addr   = addr_q;
  assign bus.ioctl_rd     = rd_q;
  assign bus.underrun     = underrun_q;

endmodule

// File: tb/tb_ioctl_upload_spi.sv
// Bench for ioctl_upload_spi: command-frame vector table, planned upload
// sequences and randomized uploads checked against a byte-stream model.
module tb_ioctl_upload_spi;
  localparam int H = 4;
  localparam logic [7:0] C_READ = 8'h57;

  typedef struct { logic [24:0] a; time due; } pend_t;
  typedef struct { logic [7:0] b [3]; int n; logic exp_up; logic [7:0] exp_idx; } vec_t;

  logic clk;
  logic res_n;
  ioctl_upload_spi_if #(.ADDR_W(25)) bus ();

  ioctl_upload_spi #(.ADDR_W(25)) dut (.clk_sys(clk), .res_n(res_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model: byte at address a is a[7:0] ^ key, returned lat cycles after rd
  pend_t      pend [$];
  time        deliv_t [$];
  int         lat = 2;
  logic [7:0] key = 8'hA5;
  int         rd_count = 0;
  int         inj_req = 0, inj_ack = 0;
  logic [7:0] inj_data = 8'h00;

  // upload stream model
  int         consumed = 0;
  bit         saw_ur = 0;
  logic [7:0] rxq [$];

  always @(negedge clk) begin
    if (!res_n) pend.delete();
    else if (bus.ioctl_rd) begin
      pend.push_back('{a: bus.ioctl_addr, due: $time + time'(lat) * 10});
      rd_count++;
    end
    bus.ioctl_din_valid = 1'b0;
    if (inj_req != inj_ack) begin
      bus.ioctl_din_valid = 1'b1;
      bus.ioctl_din       = inj_data;
      inj_ack             = inj_req;
    end else if (pend.size() > 0 && $time >= pend[0].due) begin
      bus.ioctl_din_valid = 1'b1;
      bus.ioctl_din       = pend[0].a[7:0] ^ key;
      deliv_t.push_back($time);
      void'(pend.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit last,
                      output logic [7:0] rx, output time tf);
    rx = 8'h00;
    tf = $time;
    for (int k = 0; k < nbits; k++) begin
      bus.SPI_DI = tx[7-k];
      repeat (H) @(negedge clk);
      rx[7-k] = bus.spi_do;
      bus.SPI_SCK = 1'b1;
      repeat (H) @(negedge clk);
      bus.SPI_SCK = 1'b0;
      if (last && k == nbits - 1) bus.SPI_SS = 1'b1;
      tf = $time;
    end
  endtask

  task automatic cmd_frame(input logic [7:0] b [3], input int n);
    logic [7:0] rx;
    time tf;
    bus.SPI_SS = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < n; i++) xfer(b[i], 8, i == n - 1, rx, tf);
    repeat (6) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] c);
    logic [7:0] b [3];
    b = '{c, 8'h00, 8'h00};
    cmd_frame(b, 1);
  endtask

  // Byte loaded at boundary fall tf: the next unconsumed fetch if it arrived in
  // time, else FF. Arrivals within a cycle of the cutoff may go either way.
  task automatic predict(input time tf, input logic [7:0] rx, input int nb);
    logic [7:0] dv, mask, ev;
    bit avail, take;
    time td;
    avail = consumed < deliv_t.size();
    td    = avail ? deliv_t[consumed] : 0;
    dv    = key ^ consumed[7:0];
    mask  = 8'hFF << (8 - nb);
    if (avail && td <= tf + 10)      take = 1'b1;
    else if (avail && td < tf + 30)  take = ((rx & mask) == (dv & mask));
    else                             take = 1'b0;
    ev = take ? dv : 8'hFF;
    check("rx_byte", {24'h0, rx & mask}, {24'h0, ev & mask});
    if (take) consumed++;
    else saw_ur = 1'b1;
    rxq.push_back(rx & mask);
  endtask

  task automatic read_frame(input int n, input int abort_bits);
    logic [7:0] rx;
    time tf, tf2;
    int nb;
    bus.SPI_SS = 1'b0;
    repeat (H) @(negedge clk);
    xfer(C_READ, 8, n == 0, rx, tf);
    for (int b = 0; b < n; b++) begin
      nb = (b == n - 1 && abort_bits > 0) ? abort_bits : 8;
      xfer(8'h00, nb, b == n - 1, rx, tf2);
      predict(tf, rx, nb);
      tf = tf2;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (pend.size() != 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", pend.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic model_start();
    drain();
    deliv_t.delete();
    rxq.delete();
    consumed = 0;
    rd_count = 0;
    saw_ur   = 1'b0;
  endtask

  task automatic check_totals(input string tag);
    drain();
    check({tag, "_addr"}, bus.ioctl_addr, consumed);
    check({tag, "_rdcnt"}, rd_count, consumed + 1);
    check({tag, "_underrun"}, bus.underrun, saw_ur);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [6];
    logic [7:0] lit [4];
    logic [7:0] rx;
    logic [7:0] b3 [3];
    time tf;
    int n, idx;

    vt[0] = '{'{8'h54, 8'h07, 8'h00}, 2, 1'b0, 8'h07};
    vt[1] = '{'{8'h55, 8'h00, 8'h00}, 1, 1'b1, 8'h07};
    vt[2] = '{'{8'h56, 8'h00, 8'h00}, 1, 1'b0, 8'h07};
    vt[3] = '{'{8'h99, 8'h54, 8'h01}, 3, 1'b0, 8'h07};
    vt[4] = '{'{8'h55, 8'h54, 8'hC3}, 3, 1'b1, 8'hC3};
    vt[5] = '{'{8'h56, 8'h55, 8'h56}, 3, 1'b0, 8'hC3};
    lit   = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

    res_n = 1'b0;
    bus.SPI_SCK = 1'b0;
    bus.SPI_SS  = 1'b1;
    bus.SPI_DI  = 1'b0;
    bus.ioctl_din = 8'h00;
    bus.ioctl_din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_spi_do", bus.spi_do, 0);
    check("rst_oe", bus.spi_do_oe, 0);
    check("rst_upload", bus.ioctl_upload, 0);
    check("rst_index", bus.ioctl_index, 0);
    check("rst_addr", bus.ioctl_addr, 0);
    check("rst_rd", bus.ioctl_rd, 0);
    check("rst_underrun", bus.underrun, 0);
    res_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      cmd_frame(vt[i].b, vt[i].n);
      check("vec_upload", bus.ioctl_upload, vt[i].exp_up);
      check("vec_index", bus.ioctl_index, vt[i].exp_idx);
    end

    // four-byte upload, fast memory
    key = 8'hA5; lat = 2;
    model_start();
    send1(8'h55);
    read_frame(4, 0);
    check("plan_nbytes", rxq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rxq.size()) check("plan_byte", rxq[i], lit[i]);
    check_totals("plan");
    check("plan_addr4", bus.ioctl_addr, 4);
    check("plan_rd5", rd_count, 5);

    // slow memory underruns, then recovers without skipping an address
    lat = 200;
    model_start();
    send1(8'h55);
    read_frame(4, 0);
    check("slow_underrun", bus.underrun, 1);
    lat = 2;
    read_frame(3, 0);
    read_frame(3, 0);
    check_totals("slow");

    // abort after 3 bits of the 2nd data byte; aborted byte (addr 1) is consumed
    model_start();
    send1(8'h55);
    read_frame(2, 3);
    check("abort_oe_ss_high", bus.spi_do_oe, 0);
    read_frame(1, 0);
    check("abort_next", rxq[rxq.size()-1], 8'hA7);
    b3 = '{8'h54, 8'h5A, 8'h00};
    cmd_frame(b3, 2);
    check("abort_cmd_index", bus.ioctl_index, 8'h5A);
    check_totals("abort");

    // reset while READ is running with a fetch outstanding
    lat = 200;
    model_start();
    send1(8'h55);
    bus.SPI_SS = 1'b0;
    repeat (H) @(negedge clk);
    xfer(C_READ, 8, 1'b0, rx, tf);
    xfer(8'h00, 3, 1'b0, rx, tf);
    check("pre_rst_oe", bus.spi_do_oe, 1);
    check("pre_rst_underrun", bus.underrun, 1);
    res_n = 1'b0;
    #1;
    check("mid_rst_spi_do", bus.spi_do, 0);
    check("mid_rst_oe", bus.spi_do_oe, 0);
    check("mid_rst_upload", bus.ioctl_upload, 0);
    check("mid_rst_index", bus.ioctl_index, 0);
    check("mid_rst_addr", bus.ioctl_addr, 0);
    check("mid_rst_rd", bus.ioctl_rd, 0);
    check("mid_rst_underrun", bus.underrun, 0);
    bus.SPI_SS  = 1'b1;
    bus.SPI_SCK = 1'b0;
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    repeat (4) @(negedge clk);
    inj_data = 8'h3C;
    inj_req++;
    repeat (4) @(negedge clk);
    bus.SPI_SS = 1'b0;
    repeat (H) @(negedge clk);
    xfer(C_READ, 8, 1'b0, rx, tf);
    xfer(8'h00, 8, 1'b1, rx, tf);
    repeat (6) @(negedge clk);
    check("stale_ignored", rx, 8'hFF);
    check("stale_underrun", bus.underrun, 1);
    lat = 2;
    model_start();
    send1(8'h55);
    check("restart_underrun_clr", bus.underrun, 0);
    read_frame(2, 0);
    check("restart_b0", rxq[0], 8'hA5);
    check("restart_b1", rxq[1], 8'hA4);
    check_totals("restart");

    // randomized uploads and index frames
    for (int it = 0; it < 8; it++) begin
      key = 8'($urandom);
      lat = (it % 3 == 2) ? int'($urandom_range(80, 260)) : int'($urandom_range(1, 40));
      model_start();
      send1(8'h55);
      n = int'($urandom_range(1, 5));
      read_frame(n, 0);
      lat = int'($urandom_range(1, 40));
      n = int'($urandom_range(1, 3));
      read_frame(n, 0);
      check_totals("rand");
      idx = int'($urandom_range(0, 255));
      b3 = '{8'h54, 8'(idx), 8'h00};
      cmd_frame(b3, 2);
      check("rand_index", bus.ioctl_index, idx);
      check("rand_upload", bus.ioctl_upload, 1);
    end

    send1(8'h56);
    check("end_upload", bus.ioctl_upload, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
